// File: rtl/conv_pkg.sv
// Shared definitions for the convolution output path: writeback FSM
// states, layer output count and the accumulator-to-word saturation helper.
package conv_pkg;

    typedef enum logic [1:0] {
        WB_IDLE,
        WB_RUN,
        WB_DRAIN,
        WB_DONE
    } wb_state_t;

    // Number of output words in one layer.
    function automatic int total_outputs(input int num_filters, input int output_size);
        return num_filters * output_size * output_size;
    endfunction

    // Clamp a signed value into the signed range of a w-bit word.
    // The caller keeps the low w bits of the result.
    function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                        input int w);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (v > max_v)
            return max_v;
        else if (v < min_v)
            return min_v;
        else
            return v;
    endfunction

endpackage

// File: rtl/output_writeback_if.sv
// Result stream from the controller plus the memory write port.
// master: controller / memory side, slave: the writeback block.
interface output_writeback_if #(
    parameter int ACC_WIDTH         = 32,
    parameter int DATA_WIDTH        = 16,
    parameter int MEM_ADDRESS_WIDTH = 20,
    parameter int OUTPUT_SIZE       = 64,
    parameter int NUM_FILTERS       = 32
);
    localparam int XY_W = $clog2(OUTPUT_SIZE);
    localparam int CH_W = $clog2(NUM_FILTERS);

    logic                          in_valid;
    logic                          in_ready;
    logic signed [ACC_WIDTH-1:0]   in_data;
    logic [XY_W-1:0]               in_x;
    logic [XY_W-1:0]               in_y;
    logic [CH_W-1:0]               in_ch;
    logic                          mem_we;
    logic [MEM_ADDRESS_WIDTH-1:0]  mem_write_addr;
    logic signed [DATA_WIDTH-1:0]  mem_wdata;
    logic                          mem_gnt;

    modport master (
        output in_valid, in_data, in_x, in_y, in_ch, mem_gnt,
        input  in_ready, mem_we, mem_write_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data, in_x, in_y, in_ch, mem_gnt,
        output in_ready, mem_we, mem_write_addr, mem_wdata
    );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with the head entry readable combinationally.
// Pointers carry one extra MSB so full and empty are distinguishable.
module sync_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             arst_n_in,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];

    // Pointer state; reset empties the FIFO.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + 1'b1;
            if (do_pop)
                rptr <= rptr + 1'b1;
        end
    end

    // Entry storage; contents are meaningless while the slot is not occupied.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/output_writeback.sv
// Output writeback: saturates tagged MAC results, buffers them as
// {address, word} and streams them to the memory write port, pulsing
// done once the whole layer has been written.
// Build option: define OUTPUT_RELU_EN to write negative words as 0.
module output_writeback
    import conv_pkg::*;
#(
    parameter int                           MEM_ADDRESS_WIDTH = 20,
    parameter int                           OUTPUT_SIZE       = 64,
    parameter int                           NUM_FILTERS       = 32,
    parameter int                           ACC_WIDTH         = 32,
    parameter int                           DATA_WIDTH        = 16,
    parameter int                           FIFO_DEPTH        = 8,
    parameter logic [MEM_ADDRESS_WIDTH-1:0] OUT_BASE_ADDR     = 'h20000
) (
    input  logic                clk,
    input  logic                arst_n_in,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output_writeback_if.slave   bus
);
    localparam int TOTAL   = total_outputs(NUM_FILTERS, OUTPUT_SIZE);
    localparam int CNT_W   = $clog2(TOTAL) + 1;
    localparam int ENTRY_W = MEM_ADDRESS_WIDTH + DATA_WIDTH;

    wb_state_t                      state;
    logic [CNT_W-1:0]               acc_cnt;
    logic [CNT_W-1:0]               wr_cnt;
    logic [CNT_W-1:0]               acc_next;
    logic [CNT_W-1:0]               wr_next;
    logic                           full;
    logic                           empty;
    logic                           push;
    logic                           pop;
    logic signed [ACC_WIDTH-1:0]    acc_s;
    logic signed [DATA_WIDTH-1:0]   sat_data;
    logic signed [DATA_WIDTH-1:0]   wr_data;
    logic [MEM_ADDRESS_WIDTH-1:0]   wr_addr;
    logic [ENTRY_W-1:0]             head;

    assign acc_s = bus.in_data;

    // Clamp to the word range before buffering, then apply the optional ReLU.
    always_comb begin
        sat_data = DATA_WIDTH'(sat_to_width(64'(acc_s), DATA_WIDTH));
`ifdef OUTPUT_RELU_EN
        wr_data = (sat_data < 0) ? '0 : sat_data;
`else
        wr_data = sat_data;
`endif
    end

    // Row-major (ch, y, x) word address, wrapping at the address width.
    assign wr_addr = OUT_BASE_ADDR
                   + ((MEM_ADDRESS_WIDTH'(bus.in_ch) * MEM_ADDRESS_WIDTH'(OUTPUT_SIZE)
                       + MEM_ADDRESS_WIDTH'(bus.in_y)) * MEM_ADDRESS_WIDTH'(OUTPUT_SIZE)
                      + MEM_ADDRESS_WIDTH'(bus.in_x));

    // Ready reflects the pre-pop occupancy, so a full buffer stalls for a cycle
    // even when the head is being granted.
    assign bus.in_ready = !full;
    assign push     = (state == WB_RUN) && bus.in_valid && !full;
    assign pop      = !empty && bus.mem_gnt;
    assign acc_next = acc_cnt + CNT_W'(push);
    assign wr_next  = wr_cnt + CNT_W'(pop);

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .arst_n_in (arst_n_in),
        .push      (push),
        .pop       (pop),
        .wdata     ({wr_addr, wr_data}),
        .rdata     (head),
        .full      (full),
        .empty     (empty)
    );

    // Address and data read as zero whenever nothing is queued.
    assign bus.mem_we         = !empty;
    assign bus.mem_write_addr = empty ? '0 : head[ENTRY_W-1:DATA_WIDTH];
    assign bus.mem_wdata      = empty ? '0 : head[DATA_WIDTH-1:0];

    // Layer sequencing, counters and registered status outputs.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state    <= WB_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            acc_cnt  <= '0;
            wr_cnt   <= '0;
        end else begin
            acc_cnt <= acc_next;
            wr_cnt  <= wr_next;
            done    <= 1'b0;
            if (state == WB_RUN && bus.in_valid && full)
                overflow <= 1'b1;
            case (state)
                WB_IDLE: begin
                    if (start) begin
                        state    <= WB_RUN;
                        busy     <= 1'b1;
                        acc_cnt  <= '0;
                        wr_cnt   <= '0;
                        overflow <= 1'b0;
                    end
                end
                WB_RUN: begin
                    if (acc_next == CNT_W'(TOTAL))
                        state <= WB_DRAIN;
                end
                WB_DRAIN: begin
                    if (wr_next == CNT_W'(TOTAL)) begin
                        state <= WB_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= WB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_writeback.sv
// Bench for output_writeback: a small 4x4x2 layer instance checked every
// cycle against a queue-based model, plus a default-size instance for the
// absolute address example.
module tb_output_writeback;

    localparam int OS    = 4;
    localparam int NF    = 2;
    localparam int TOTAL = NF * OS * OS;
    localparam int DEPTH = 8;

    typedef struct {
        logic [19:0]        addr;
        logic signed [15:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic arst_n;
    logic start, busy, done, overflow;
    logic start64, busy64, done64, overflow64;

    int n_chk = 0;
    int n_fail = 0;

    output_writeback_if #(.OUTPUT_SIZE(OS), .NUM_FILTERS(NF)) bus ();
    output_writeback_if bus64 ();

    output_writeback #(.OUTPUT_SIZE(OS), .NUM_FILTERS(NF)) dut (
        .clk(clk), .arst_n_in(arst_n), .start(start), .busy(busy),
        .done(done), .overflow(overflow), .bus(bus)
    );

    output_writeback dut64 (
        .clk(clk), .arst_n_in(arst_n), .start(start64), .busy(busy64),
        .done(done64), .overflow(overflow64), .bus(bus64)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    ent_t m_q[$];
    bit   m_busy, m_done, m_ovf;
    int   m_acc, m_wr;

    function automatic logic signed [15:0] m_sat(input int d);
        logic signed [15:0] r;
        if (d > 32767)       r = 16'sh7fff;
        else if (d < -32768) r = 16'sh8000;
        else                 r = 16'(d);
`ifdef OUTPUT_RELU_EN
        if (r < 0) r = 0;
`endif
        return r;
    endfunction

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            m_q.delete();
            m_busy = 0; m_done = 0; m_ovf = 0; m_acc = 0; m_wr = 0;
        end else begin
            bit was_done, accepting, do_pop, do_push;
            ent_t e;
            was_done  = m_done;
            m_done    = 0;
            accepting = m_busy && (m_acc < TOTAL);
            do_pop    = (m_q.size() > 0) && bus.mem_gnt;
            do_push   = accepting && bus.in_valid && (m_q.size() < DEPTH);
            if (accepting && bus.in_valid && m_q.size() >= DEPTH) m_ovf = 1;
            e.addr = 20'('h20000 + (int'(bus.in_ch) * OS + int'(bus.in_y)) * OS + int'(bus.in_x));
            e.data = m_sat(int'(bus.in_data));
            if (do_pop) begin
                void'(m_q.pop_front());
                m_wr++;
                if (m_wr == TOTAL) begin m_busy = 0; m_done = 1; end
            end
            if (do_push) begin
                m_q.push_back(e);
                m_acc++;
            end
            if (!m_busy && !was_done && !m_done && start) begin
                m_busy = 1; m_acc = 0; m_wr = 0; m_ovf = 0;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (arst_n) begin
            chk("in_ready", bus.in_ready, m_q.size() < DEPTH);
            chk("mem_we", bus.mem_we, m_q.size() > 0);
            if (m_q.size() > 0) begin
                chk("mem_addr", bus.mem_write_addr, m_q[0].addr);
                chk("mem_wdata", bus.mem_wdata, m_q[0].data);
            end
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("overflow", overflow, m_ovf);
        end
    end

    // Write monitor: grants, address coverage and done timing.
    int wr_mon, done_cnt, oob, cyc, last_gnt_cyc, done_cyc;
    int hits[TOTAL];
    always @(negedge clk) begin
        cyc++;
        if (arst_n && bus.mem_we && bus.mem_gnt) begin
            int idx;
            wr_mon++;
            idx = int'(bus.mem_write_addr) - 'h20000;
            if (idx >= 0 && idx < TOTAL) hits[idx]++;
            else oob++;
            if (wr_mon == TOTAL) last_gnt_cyc = cyc;
        end
        if (arst_n && done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    bit gnt_rand = 0;
    always @(posedge clk) begin
        #1;
        if (gnt_rand) bus.mem_gnt = 1'($urandom_range(0, 1));
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int i, input int d);
        bus.in_x    = 2'(i % OS);
        bus.in_y    = 2'((i / OS) % OS);
        bus.in_ch   = 1'(i / (OS * OS));
        bus.in_data = d;
    endtask

    function automatic int data_of(input int i);
        return i * 2900 - 45000;
    endfunction

    task automatic send_at(input int x, input int y, input int ch, input int d);
        int t = 0;
        bus.in_valid = 1'b0;
        while (!bus.in_ready && t < 300) begin
            @(posedge clk); #2; t++;
        end
        if (t >= 300) begin
            n_chk++; n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", t);
        end
        bus.in_x = 2'(x); bus.in_y = 2'(y); bus.in_ch = 1'(ch); bus.in_data = d;
        bus.in_valid = 1'b1;
        @(posedge clk); #2;
        bus.in_valid = 1'b0;
    endtask

    task automatic send(input int i);
        send_at(i % OS, (i / OS) % OS, i / (OS * OS), data_of(i));
    endtask

    task automatic send_raw(input int i);
        drive(i, data_of(i));
        bus.in_valid = 1'b1;
        @(posedge clk); #2;
        bus.in_valid = 1'b0;
    endtask

    task automatic layer_begin();
        wr_mon = 0; done_cnt = 0; oob = 0; last_gnt_cyc = 0; done_cyc = 0;
        for (int i = 0; i < TOTAL; i++) hits[i] = 0;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
    endtask

    task automatic finish_layer(input string name);
        int t = 0;
        int nbad = 0;
        while (done_cnt == 0 && t < 3000) begin
            @(posedge clk); t++;
        end
        if (t >= 3000) begin
            n_chk++; n_fail++;
            $display("FAIL %s_done_timeout: no done after %0d cycles", name, t);
        end
        repeat (2) @(posedge clk);
        #2;
        for (int i = 0; i < TOTAL; i++) if (hits[i] != 1) nbad++;
        chk({name, "_writes"}, wr_mon, TOTAL);
        chk({name, "_addr_once"}, nbad + oob, 0);
        chk({name, "_done_pulses"}, done_cnt, 1);
        chk({name, "_done_latency"}, done_cyc - last_gnt_cyc, 1);
        chk({name, "_busy_low"}, busy, 1'b0);
    endtask

    task automatic check_reset_state();
        chk("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_addr", bus.mem_write_addr, 0);
        chk("rst_wdata", {48'd0, bus.mem_wdata}, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        arst_n = 1'b1;
        start = 1'b0; start64 = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = 0; bus.in_x = 0; bus.in_y = 0; bus.in_ch = 0;
        bus.mem_gnt = 1'b0;
        bus64.in_valid = 1'b0; bus64.in_data = 0; bus64.in_x = 0; bus64.in_y = 0;
        bus64.in_ch = 0; bus64.mem_gnt = 1'b1;
        #3 arst_n = 1'b0;
        #4;
        check_reset_state();
        chk("rst64_mem_we", bus64.mem_we, 1'b0);
        @(negedge clk); arst_n = 1'b1;
        @(posedge clk); #2;

        // Default-size instance: x=2, y=1, ch=0 lands at 'h20042.
        start64 = 1'b1;
        @(posedge clk); #2;
        start64 = 1'b0;
        bus64.in_x = 6'd2; bus64.in_y = 6'd1; bus64.in_ch = 5'd0; bus64.in_data = 100;
        bus64.in_valid = 1'b1;
        @(posedge clk); #2;
        bus64.in_valid = 1'b0;
        chk("w64_mem_we", bus64.mem_we, 1'b1);
        chk("w64_addr", bus64.mem_write_addr, 'h20042);
        chk("w64_wdata", {48'd0, bus64.mem_wdata}, 100);
        chk("w64_busy", busy64, 1'b1);

        // Layer 1: literal saturation cases first, then the rest with random grants.
        bus.mem_gnt = 1'b1;
        layer_begin();
        send_at(2, 1, 0, 100);
        chk("lit_mem_we", bus.mem_we, 1'b1);
        chk("lit_addr", bus.mem_write_addr, 'h20006);
        chk("lit_wdata", {48'd0, bus.mem_wdata}, 100);
        send_at(3, 0, 0, 40000);
        chk("sat_pos_addr", bus.mem_write_addr, 'h20003);
        chk("sat_pos", {48'd0, bus.mem_wdata}, 'h7fff);
        send_at(0, 1, 0, -40000);
        chk("sat_neg_addr", bus.mem_write_addr, 'h20004);
`ifdef OUTPUT_RELU_EN
        chk("sat_neg", {48'd0, bus.mem_wdata}, 0);
`else
        chk("sat_neg", {48'd0, bus.mem_wdata}, 'h8000);
`endif
        gnt_rand = 1;
        for (int i = 0; i < TOTAL; i++)
            if (i != 6 && i != 3 && i != 4) send(i);
        finish_layer("layer1");
        gnt_rand = 0;

        // Layer 2: stalled write port, overflow, drain, then full-buffer push/pop.
        bus.mem_gnt = 1'b0;
        #1;
        layer_begin();
        for (int i = 0; i < 8; i++) send_raw(i);
        chk("full_in_ready", bus.in_ready, 1'b0);
        chk("full_no_ovf", overflow, 1'b0);
        send_raw(8);
        chk("ovf_set", overflow, 1'b1);
        bus.mem_gnt = 1'b1;
        repeat (12) @(posedge clk);
        #2;
        chk("drain8_writes", wr_mon, 8);
        chk("drain8_empty", bus.mem_we, 1'b0);
        bus.mem_gnt = 1'b0;
        for (int i = 8; i < 16; i++) send(i);
        chk("refill_in_ready", bus.in_ready, 1'b0);
        bus.mem_gnt = 1'b1;
        for (int i = 16; i < TOTAL; i++) send(i);
        finish_layer("layer2");
        chk("layer2_ovf_sticky", overflow, 1'b1);

        // Layer 3: reset while draining with five entries queued.
        layer_begin();
        chk("start_clears_ovf", overflow, 1'b0);
        for (int i = 0; i < 27; i++) send(i);
        repeat (4) @(posedge clk);
        #2;
        bus.mem_gnt = 1'b0;
        for (int i = 27; i < TOTAL; i++) send(i);
        chk("drain_mem_we", bus.mem_we, 1'b1);
        chk("drain_busy", busy, 1'b1);
        #1 arst_n = 1'b0;
        #1;
        chk("mid_rst_mem_we", bus.mem_we, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_in_ready", bus.in_ready, 1'b1);
        @(negedge clk); arst_n = 1'b1;
        @(posedge clk); #2;

        // Layer 4: clean full layer after reset, random grants.
        layer_begin();
        gnt_rand = 1;
        for (int i = 0; i < TOTAL; i++) send(i);
        finish_layer("layer4");
        gnt_rand = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
